spike_rate_decoder: RTL and testbench
=====================================

Name: spike_rate_decoder

Overview:
- Output-side counterpart of the spiking neuron core. The core encodes an input current into spike trains; this block decodes spike trains back into magnitudes.
- Counts spikes per channel over a fixed window of enabled cycles.
- At window end, snapshots the counts into a shadow bank and streams them out one channel at a time over a valid/ready interface.
- Sits between the neuron core's spike outputs and the uio/readout logic of the top wrapper.

Parameters:
- N_CH, 8, number of spike channels; must be a power of two, maximum 8.
- CNT_W, 8, width of each rate count; counts saturate at 2^CNT_W-1.
- WIN_LEN, 16, window length in enabled cycles; legal range 1..2^CNT_W.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- ena  input  1  design enable; low freezes window counting and accumulation.
- clear  input  1  synchronous restart: zeroes counters, aborts drain, clears overrun.
- spike_in  input  N_CH  one spike bit per channel, sampled each enabled cycle.
- rate_out  output  CNT_W  count of the channel currently presented.
- rate_ch  output  $clog2(N_CH) (minimum 1)  index of the channel currently presented.
- rate_valid  output  1  rate_out and rate_ch are valid.
- rate_ready  input  1  consumer accepts the current beat.
- win_overrun  output  1  sticky flag: a window ended while the drain was still busy.
- winner_ch  output  $clog2(N_CH)  argmax channel (optional feature).
- winner_valid  output  1  winner_ch is valid (optional feature).

Behaviour:
- Reset (rst_n=0 on a clock edge): window counter=0, all accumulators=0, shadow bank=0, state=IDLE. Outputs: rate_valid=0, rate_ch=0, rate_out=0, win_overrun=0, winner_valid=0, winner_ch=0.
- Accumulation, on each cycle with ena=1: acc[i] = sat(acc[i] + spike_in[i]), saturating at 2^CNT_W-1. win_cnt increments and wraps after WIN_LEN-1. With ena=0, acc and win_cnt hold.
- Window end is the cycle with ena=1 and win_cnt==WIN_LEN-1:
  - If state==IDLE: shadow[i] takes acc[i] including this cycle's spike. Next cycle: state=DRAIN, rate_ch=0, rate_valid=1.
  - If state==DRAIN: the snapshot is discarded, shadow is untouched, and win_overrun is set to 1.
  - In both cases acc is zeroed, so the next window starts from 0 on the following cycle.
- FSM has two states:
  - IDLE: rate_valid=0.
  - DRAIN: rate_valid=1, rate_out=shadow[rate_ch]. A handshake occurs when rate_valid and rate_ready are both 1. On a handshake with rate_ch<N_CH-1, rate_ch increments. On a handshake with rate_ch==N_CH-1, the FSM returns to IDLE and rate_ch goes to 0.
  - rate_out and rate_ch are stable while valid=1 and ready=0.
- Output register latency: spike sampled on window-end cycle T, first beat valid at T+1. With ready held high, the drain takes exactly N_CH cycles.
- Drain runs regardless of ena.
- clear=1 acts like reset, except the shadow bank holds its contents. Clear has priority over a window end and a handshake in the same cycle.
- win_overrun clears only on reset or clear.
- WIN_LEN=1: every enabled cycle is a window end.

Optional Feature:
- Macro: SPIKE_WINNER_EN.
- Defined: during DRAIN, a running max and index are updated on each handshake; strict greater-than, so ties go to the lowest index.
  - On the cycle after the final handshake: winner_valid=1 and winner_ch=argmax.
  - winner_valid holds until the next DRAIN begins, clear, or reset.
- Undefined: winner_ch and winner_valid are tied to 0; no compare logic is built.

Decomposition:
- Package snn_pkg holds:
  - the FSM state enum (IDLE, DRAIN);
  - defaults for N_CH, CNT_W and WIN_LEN;
  - the CNT_MAX constant.
- Sub-module spike_counter: one saturating CNT_W accumulator with inputs inc, en and zero. Instantiate N_CH copies.

Test Plan:
- Reset mid-drain: assert rst_n=0 during DRAIN -> next cycle rate_valid=0, win_overrun=0, counts restart from 0.
- Basic decode: WIN_LEN=16, ready=1, channel 2 spikes every cycle, channel 5 every other cycle, others 0. -> Beats at ch0..7 give 0,0,16,0,0,8,0,0; first beat one cycle after the 16th enabled cycle.
- Saturation: CNT_W=4, WIN_LEN=16, channel 0 spikes every cycle -> rate_out=15 for ch0.
- Backpressure and overrun: ready=0 for 40 cycles with WIN_LEN=16 -> ch0 beat stable throughout, win_overrun=1 after the second window end, first-window values intact once ready=1.
- ena gating and clear: ena low for 10 cycles mid-window -> window end delayed 10 cycles. Clear coincident with a window end -> no drain, win_overrun=0.
- SPIKE_WINNER_EN: counts 3,9,9,1,... -> winner_ch=1, winner_valid=1 one cycle after the last beat. Build without the macro -> winner_* stays 0.

Source files
------------

// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
// Shared types and defaults for the spike-rate decoder.
//   state_t      : drain FSM states (IDLE, DRAIN)
//   N_CH_DEF     : default number of spike channels
//   CNT_W_DEF    : default rate-count width
//   WIN_LEN_DEF  : default window length in enabled cycles
//   CNT_MAX      : saturation value for the default count width
//   cnt_max()    : saturation value for an arbitrary count width
// -----------------------------------------------------------------------------
package snn_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam int N_CH_DEF    = 8;
    localparam int CNT_W_DEF   = 8;
    localparam int WIN_LEN_DEF = 16;
    localparam int CNT_MAX     = (1 << CNT_W_DEF) - 1;

    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/spike_counter.sv
// -----------------------------------------------------------------------------
// spike_counter
// One saturating per-channel spike accumulator.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   inc    : spike bit for this channel
//   en     : accumulate this cycle
//   zero   : restart from 0 next cycle (wins over accumulation)
//   sum    : count including this cycle's spike (what a snapshot captures)
// -----------------------------------------------------------------------------
module spike_counter
    import snn_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             en,
    input  logic             zero,
    output logic [CNT_W-1:0] sum
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(cnt_max(CNT_W));

    logic [CNT_W-1:0] r_cnt;

    // NOTE: always_comb gives a full assignment on every path, so no latch can be inferred.
    always_comb begin
        sum = r_cnt;
        if (en && inc && (r_cnt != SAT)) begin
            sum = r_cnt + 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (zero) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= sum;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// spike_rate_decoder
// Counts spikes per channel over a window of enabled cycles, snapshots the
// counts at window end and streams them out one channel per valid/ready beat.
// Optional argmax tracking is built when SPIKE_WINNER_EN is defined.
//   clk, rst_n    : clock and synchronous active-low reset
//   ena           : enable for window counting and accumulation
//   clear         : synchronous restart (shadow bank keeps its contents)
//   spike_in      : one spike bit per channel
//   rate_out      : count of the presented channel (0 while idle)
//   rate_ch       : index of the presented channel
//   rate_valid    : beat valid
//   rate_ready    : consumer accepts the beat
//   win_overrun   : sticky, a window ended while still draining
//   winner_ch     : argmax channel of the last drained snapshot
//   winner_valid  : winner_ch is valid
// -----------------------------------------------------------------------------
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter  int N_CH    = N_CH_DEF,
    parameter  int CNT_W   = CNT_W_DEF,
    parameter  int WIN_LEN = WIN_LEN_DEF,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clear,
    input  logic [N_CH-1:0]  spike_in,
    output logic [CNT_W-1:0] rate_out,
    output logic [CH_W-1:0]  rate_ch,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             win_overrun,
    output logic [CH_W-1:0]  winner_ch,
    output logic             winner_valid
);

    localparam int              WIN_W    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);

    state_t           r_state;
    logic [CH_W-1:0]  r_ch;
    logic [CNT_W-1:0] r_shadow [N_CH];
    logic             r_overrun;
    logic [WIN_W-1:0] r_win_cnt;

    logic [CNT_W-1:0] w_sum [N_CH];
    logic             w_win_end;
    logic             w_hs;
    logic             w_zero;

    assign w_win_end = ena && (r_win_cnt == WIN_LAST);
    assign w_hs      = (r_state == DRAIN) && rate_ready;
    assign w_zero    = clear || w_win_end;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_cnt
        spike_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (spike_in[gi]),
            .en    (ena),
            .zero  (w_zero),
            .sum   (w_sum[gi])
        );
    end

    assign rate_valid  = (r_state == DRAIN);
    assign rate_ch     = r_ch;
    assign rate_out    = rate_valid ? r_shadow[r_ch] : '0;
    assign win_overrun = r_overrun;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ch      <= '0;
            r_overrun <= 1'b0;
            r_win_cnt <= '0;
            // NOTE: the shadow bank is a small flop array, not a RAM, so it can be reset.
            for (int i = 0; i < N_CH; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (clear) begin
            r_state   <= IDLE;
            r_ch      <= '0;
            r_overrun <= 1'b0;
            r_win_cnt <= '0;
        end else begin
            if (ena) begin
                r_win_cnt <= w_win_end ? '0 : r_win_cnt + 1'b1;
            end
            if (w_hs) begin
                if (r_ch == CH_LAST) begin
                    r_state <= IDLE;
                    r_ch    <= '0;
                end else begin
                    r_ch <= r_ch + 1'b1;
                end
            end
            // A window end while still draining drops the snapshot; the
            // accumulators are zeroed either way by w_zero.
            if (w_win_end) begin
                if (r_state == IDLE) begin
                    for (int i = 0; i < N_CH; i++) begin
                        r_shadow[i] <= w_sum[i];
                    end
                    r_state <= DRAIN;
                    r_ch    <= '0;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

`ifdef SPIKE_WINNER_EN
    logic [CNT_W-1:0] r_max;
    logic [CH_W-1:0]  r_max_ch;
    logic [CH_W-1:0]  r_winner_ch;
    logic             r_winner_valid;
    logic [CNT_W-1:0] w_cur;
    logic             w_take;
    logic [CH_W-1:0]  w_best_ch;

    // Channel 0 seeds the running max; strict compare keeps ties at the lower index.
    assign w_cur     = r_shadow[r_ch];
    assign w_take    = (r_ch == '0) || (w_cur > r_max);
    assign w_best_ch = w_take ? r_ch : r_max_ch;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_max          <= '0;
            r_max_ch       <= '0;
            r_winner_ch    <= '0;
            r_winner_valid <= 1'b0;
        end else begin
            if (w_win_end && (r_state == IDLE)) begin
                r_winner_valid <= 1'b0;
            end
            if (w_hs) begin
                if (w_take) begin
                    r_max    <= w_cur;
                    r_max_ch <= r_ch;
                end
                if (r_ch == CH_LAST) begin
                    r_winner_valid <= 1'b1;
                    r_winner_ch    <= w_best_ch;
                end
            end
        end
    end

    assign winner_ch    = r_winner_ch;
    assign winner_valid = r_winner_valid;
`else
    assign winner_ch    = '0;
    assign winner_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
module tb_spike_rate_decoder;

    localparam int N_CH    = 8;
    localparam int CNT_W   = 8;
    localparam int WIN_LEN = 16;
    localparam int MAXV    = 255;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic             clear;
    logic [N_CH-1:0]  spike_in;
    logic             rate_ready;

    logic [CNT_W-1:0] rate_out;
    logic [2:0]       rate_ch;
    logic             rate_valid;
    logic             win_overrun;
    logic [2:0]       winner_ch;
    logic             winner_valid;

    logic [3:0]       rate_out_s;
    logic [2:0]       rate_ch_s;
    logic             rate_valid_s;
    logic             win_overrun_s;
    logic [2:0]       winner_ch_s;
    logic             winner_valid_s;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spike_rate_decoder #(.N_CH(N_CH), .CNT_W(CNT_W), .WIN_LEN(WIN_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .spike_in(spike_in),
        .rate_out(rate_out), .rate_ch(rate_ch), .rate_valid(rate_valid),
        .rate_ready(rate_ready), .win_overrun(win_overrun),
        .winner_ch(winner_ch), .winner_valid(winner_valid)
    );

    // Narrow-count instance used for the saturation case; shares all inputs.
    spike_rate_decoder #(.N_CH(N_CH), .CNT_W(4), .WIN_LEN(WIN_LEN)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .spike_in(spike_in),
        .rate_out(rate_out_s), .rate_ch(rate_ch_s), .rate_valid(rate_valid_s),
        .rate_ready(rate_ready), .win_overrun(win_overrun_s),
        .winner_ch(winner_ch_s), .winner_valid(winner_valid_s)
    );

    // ---------------- reference model ----------------
    typedef struct { int ch; int val; } beat_t;
    int    m_acc [N_CH];
    int    m_win;
    beat_t m_q [$];
    bit    m_ovr;
    bit    m_wv;
    int    m_wch;
    int    m_pend_arg;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void model_edge();
        bit busy;
        if (!rst_n || clear) begin
            foreach (m_acc[i]) m_acc[i] = 0;
            m_win = 0;
            m_q.delete();
            m_ovr = 0;
            m_wv  = 0;
            m_wch = 0;
            return;
        end
        busy = (m_q.size() > 0);
        if (busy && rate_ready) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
                m_wv  = 1;
                m_wch = m_pend_arg;
            end
        end
        if (ena) begin
            foreach (m_acc[i]) begin
                m_acc[i] = m_acc[i] + int'(spike_in[i]);
                if (m_acc[i] > MAXV) m_acc[i] = MAXV;
            end
            if (m_win == WIN_LEN - 1) begin
                m_win = 0;
                if (!busy) begin
                    m_pend_arg = 0;
                    for (int i = 0; i < N_CH; i++) begin
                        beat_t b;
                        b.ch  = i;
                        b.val = m_acc[i];
                        m_q.push_back(b);
                        if (m_acc[i] > m_acc[m_pend_arg]) m_pend_arg = i;
                    end
                    m_wv = 0;
                end else begin
                    m_ovr = 1;
                end
                foreach (m_acc[i]) m_acc[i] = 0;
            end else begin
                m_win++;
            end
        end
    endfunction

    task automatic compare_model();
        bit v;
        v = (m_q.size() > 0);
        check("m_valid",   int'(rate_valid),  int'(v));
        check("m_ch",      int'(rate_ch),     v ? m_q[0].ch  : 0);
        check("m_out",     int'(rate_out),    v ? m_q[0].val : 0);
        check("m_overrun", int'(win_overrun), int'(m_ovr));
`ifdef SPIKE_WINNER_EN
        check("m_win_vld", int'(winner_valid), int'(m_wv));
        check("m_win_ch",  int'(winner_ch),    m_wch);
`else
        check("m_win_vld", int'(winner_valid), 0);
        check("m_win_ch",  int'(winner_ch),    0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ena = 1'b0; clear = 1'b0; spike_in = '0; rate_ready = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // ---------------- table-driven basic decode ----------------
    typedef struct {
        logic            ena;
        logic [N_CH-1:0] spike;
        logic            ready;
        logic            exp_valid;
        int              exp_ch;
        int              exp_out;
        int              exp_sat;
    } vec_t;

    vec_t tbl [24];
    int   beat_full [8] = '{0, 0, 16, 0, 0, 8, 0, 0};
    int   beat_sat  [8] = '{0, 0, 15, 0, 0, 8, 0, 0};
    int   bp_beats  [8] = '{16, 0, 0, 16, 0, 0, 0, 0};

    initial begin
        for (int k = 0; k < 24; k++) begin
            tbl[k].ena   = 1'b1;
            tbl[k].ready = 1'b1;
            tbl[k].spike = (k < 16) ? (8'h04 | ((k % 2 == 0) ? 8'h20 : 8'h00)) : 8'h00;
            tbl[k].exp_valid = (k >= 15) && (k <= 22);
            tbl[k].exp_ch    = tbl[k].exp_valid ? k - 15 : 0;
            tbl[k].exp_out   = tbl[k].exp_valid ? beat_full[k - 15] : 0;
            tbl[k].exp_sat   = tbl[k].exp_valid ? beat_sat[k - 15] : 0;
        end

        // Reset state
        do_reset();
        check("rst_valid",   int'(rate_valid),   0);
        check("rst_ch",      int'(rate_ch),      0);
        check("rst_out",     int'(rate_out),     0);
        check("rst_overrun", int'(win_overrun),  0);
        check("rst_win_vld", int'(winner_valid), 0);
        check("rst_win_ch",  int'(winner_ch),    0);

        // Basic decode + saturation on the 4-bit instance
        for (int k = 0; k < 24; k++) begin
            ena = tbl[k].ena; spike_in = tbl[k].spike; rate_ready = tbl[k].ready;
            step();
            check("tbl_valid",   int'(rate_valid),   int'(tbl[k].exp_valid));
            check("tbl_ch",      int'(rate_ch),      tbl[k].exp_ch);
            check("tbl_out",     int'(rate_out),     tbl[k].exp_out);
            check("tbl_valid_s", int'(rate_valid_s), int'(tbl[k].exp_valid));
            check("tbl_ch_s",    int'(rate_ch_s),    tbl[k].exp_ch);
            check("tbl_sat_out", int'(rate_out_s),   tbl[k].exp_sat);
        end

        // Backpressure and overrun
        do_reset();
        ena = 1'b1; spike_in = 8'h09; rate_ready = 1'b0;
        for (int k = 0; k < 56; k++) begin
            step();
            if (k >= 15) begin
                check("bp_valid", int'(rate_valid), 1);
                check("bp_ch",    int'(rate_ch),    0);
                check("bp_out",   int'(rate_out),   16);
            end
            check("bp_overrun",   int'(win_overrun),   (k >= 31) ? 1 : 0);
            check("bp_overrun_s", int'(win_overrun_s), (k >= 31) ? 1 : 0);
        end
        rate_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            check("bp_drain_ch",  int'(rate_ch),  j);
            check("bp_drain_out", int'(rate_out), bp_beats[j]);
            step();
        end

        // ena gating: window end delayed by 10 disabled cycles
        do_reset();
        spike_in = 8'h01; rate_ready = 1'b1;
        for (int k = 0; k < 26; k++) begin
            ena = (k < 5 || k >= 15) ? 1'b1 : 1'b0;
            step();
            if (k == 15 || k == 24) check("gate_not_yet", int'(rate_valid), 0);
            if (k == 25) begin
                check("gate_valid", int'(rate_valid), 1);
                check("gate_out",   int'(rate_out),   16);
            end
        end

        // Clear coincident with a window end while overrun is set
        do_reset();
        ena = 1'b1; spike_in = 8'h00; rate_ready = 1'b0;
        for (int k = 0; k < 47; k++) begin
            step();
            if (k == 31) check("clr_pre_overrun", int'(win_overrun), 1);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_valid",   int'(rate_valid),  0);
        check("clr_overrun", int'(win_overrun), 0);

        // Reset in the middle of a drain
        do_reset();
        ena = 1'b1; spike_in = 8'h02; rate_ready = 1'b1;
        for (int k = 0; k < 17; k++) step();
        check("mid_pre_valid", int'(rate_valid), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_valid",   int'(rate_valid),  0);
        check("mid_overrun", int'(win_overrun), 0);
        for (int k = 0; k < 17; k++) step();
        check("mid_restart_ch",  int'(rate_ch),  1);
        check("mid_restart_out", int'(rate_out), 16);

        // Winner: counts 3,9,9,1,0,0,0,0
        do_reset();
        ena = 1'b1; rate_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            spike_in = '0;
            if (k < 16) begin
                spike_in[0] = (k < 3);
                spike_in[1] = (k < 9);
                spike_in[2] = (k < 9);
                spike_in[3] = (k < 1);
            end
            step();
            if (k == 22) check("win_early", int'(winner_valid), 0);
        end
`ifdef SPIKE_WINNER_EN
        check("win_valid",   int'(winner_valid),   1);
        check("win_ch",      int'(winner_ch),      1);
        check("win_valid_s", int'(winner_valid_s), 1);
        check("win_ch_s",    int'(winner_ch_s),    1);
`else
        check("win_valid",   int'(winner_valid),   0);
        check("win_ch",      int'(winner_ch),      0);
        check("win_valid_s", int'(winner_valid_s), 0);
        check("win_ch_s",    int'(winner_ch_s),    0);
`endif

        // Randomized run against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            ena        = ($urandom_range(0, 9) < 8);
            spike_in   = N_CH'($urandom);
            rate_ready = ($urandom_range(0, 9) < 6);
            clear      = ($urandom_range(0, 199) == 0);
            rst_n      = ($urandom_range(0, 499) != 0);
            step();
        end
        rst_n = 1'b1; clear = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
